// File: rtl/cic_interp_comb.sv
// Input comb and zero-stuffing upsampler for the CIC interpolator: one first-difference
// value per accepted PCM sample, followed by R-1 stuffed zeros, R = 2^os_sel.
module cic_interp_comb #(
    parameter int ODW = 16,
    parameter int IDW = 23
) (
    input  logic           clk_div,
    input  logic           reset_n,
    input  logic [2:0]     os_sel,
    input  logic [ODW-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [IDW-1:0] data_out,
    output logic           out_valid,
    output logic           out_stb,
    output logic           underrun
);

    localparam int SXW = IDW - ODW - 1;

    logic [2:0]     os_sel_q;
    logic [5:0]     cnt_q, cnt_d;
    logic [ODW-1:0] prev_q, prev_d;
    logic [IDW-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           stb_q, stb_d;
    logic           und_q, und_d;

    logic           os_legal;
    logic           enabled;
    logic           phase0;
    logic           cnt_last;
    logic [6:0]     r_m1;
    logic [ODW:0]   diff;
    logic [IDW-1:0] diff_ext;

    // A changed os_sel disables the block for one cycle, restarting the stream cleanly.
    assign os_legal = (os_sel != 3'd0) && (os_sel != 3'd7);
    assign enabled  = os_legal && (os_sel == os_sel_q);
    assign phase0   = (cnt_q == 6'd0);
    assign r_m1     = (7'd1 << os_sel) - 7'd1;
    assign cnt_last = ({1'b0, cnt_q} == r_m1);
    assign in_ready = enabled && phase0;

    // First difference at ODW+1 bits cannot overflow.
    assign diff = {in_data[ODW-1], in_data} - {prev_q[ODW-1], prev_q};

    generate
        if (SXW > 0) begin : g_sext
            assign diff_ext = {{SXW{diff[ODW]}}, diff};
        end else begin : g_nosext
            assign diff_ext = diff;
        end
    endgenerate

    always_comb begin
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        data_d  = '0;
        valid_d = 1'b0;
        stb_d   = 1'b0;
        und_d   = 1'b0;
        if (!enabled) begin
            cnt_d  = 6'd0;
            prev_d = '0;
        end else begin
            cnt_d   = cnt_last ? 6'd0 : cnt_q + 6'd1;
            valid_d = 1'b1;
            if (phase0) begin
                stb_d = 1'b1;
                if (in_valid) begin
                    prev_d = in_data;
                    data_d = diff_ext;
                end else begin
                    // Missing sample: emit zero, keep prev so the input reads as held.
                    und_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            os_sel_q <= 3'd0;
            cnt_q    <= 6'd0;
            prev_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            stb_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            os_sel_q <= os_sel;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            stb_q    <= stb_d;
            und_q    <= und_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign out_stb   = stb_q;
    assign underrun  = und_q;

endmodule
